// File: rtl/matrix_pkg.sv
// Shared types and helpers for the sequential matrix add/subtract block.
// Element (i,j) of a flat-packed matrix has flat index k = i*DIM + j.
package matrix_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 32'sd1) / den;
  endfunction

  // Bit offset of the element with flat index k.
  function automatic int elem_offset(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/element_addsub.sv
// One combinational lane: signed A+B / A-B with overflow detect.
// Define MATRIX_SAT_EN to clamp overflowing results instead of wrapping.
module element_addsub
  import matrix_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     op,
  output logic        [DATA_W-1:0] res,
  output logic                     ovf
);

  logic signed [DATA_W:0] a_x_s;
  logic signed [DATA_W:0] b_x_s;
  logic signed [DATA_W:0] sum_s;

  assign a_x_s = {a[DATA_W-1], a};
  assign b_x_s = {b[DATA_W-1], b};

  // Widened arithmetic so the true result is always representable.
  always_comb begin
    sum_s = {(DATA_W+1){1'b0}};
    if (op == OP_SUB) begin
      sum_s = a_x_s - b_x_s;
    end else begin
      sum_s = a_x_s + b_x_s;
    end
  end

  assign ovf = sum_s[DATA_W] ^ sum_s[DATA_W-1];

`ifdef MATRIX_SAT_EN
  // Clamp toward the sign of the true result.
  always_comb begin
    res = sum_s[DATA_W-1:0];
    if (ovf) begin
      if (sum_s[DATA_W]) begin
        res = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        res = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end else begin
      res = sum_s[DATA_W-1:0];
    end
  end
`else
  assign res = sum_s[DATA_W-1:0];
`endif

endmodule

// File: rtl/matrix_addsub_seq.sv
// Sequential element-wise matrix add/subtract, LANES elements per clock,
// start/busy/done handshake, sticky overflow. Saturation via MATRIX_SAT_EN.
module matrix_addsub_seq
  import matrix_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIM    = 5,
  parameter int LANES  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      op,
  input  logic [DIM*DIM*DATA_W-1:0] matrix_A,
  input  logic [DIM*DIM*DATA_W-1:0] matrix_B,
  output logic                      busy,
  output logic                      done,
  output logic [DIM*DIM*DATA_W-1:0] result_out,
  output logic                      overflow
);

  localparam int NELEM = DIM * DIM;
  localparam int NGRP  = ceil_div(NELEM, LANES);
  localparam int MAT_W = NELEM * DATA_W;
  localparam int IDX_W = $clog2(NELEM + LANES) + 1;

  localparam logic [IDX_W-1:0] NELEM_L = IDX_W'(NELEM);
  localparam logic [IDX_W-1:0] LAST_L  = IDX_W'((NGRP - 1) * LANES);
  localparam logic [IDX_W-1:0] STEP_L  = IDX_W'(LANES);

  state_t             state_r;
  logic [MAT_W-1:0]   a_r;
  logic [MAT_W-1:0]   b_r;
  logic [MAT_W-1:0]   result_r;
  logic               op_r;
  logic [IDX_W-1:0]   idx_r;
  logic               ovf_r;
  logic               busy_r;
  logic               done_r;

  logic [IDX_W-1:0]   lane_idx_s [LANES];
  logic [DATA_W-1:0]  lane_res_s [LANES];
  logic [LANES-1:0]   lane_ok_s;
  logic [LANES-1:0]   lane_ovf_s;
  logic               any_ovf_s;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0] sel_s;

    assign lane_idx_s[l] = idx_r + IDX_W'(l);
    assign lane_ok_s[l]  = lane_idx_s[l] < NELEM_L;
    // Masked lanes read element 0 so the select never leaves the operand.
    assign sel_s         = lane_ok_s[l] ? lane_idx_s[l] : {IDX_W{1'b0}};

    element_addsub #(.DATA_W(DATA_W)) u_elem (
      .a   (a_r[elem_offset(int'(sel_s), DATA_W) +: DATA_W]),
      .b   (b_r[elem_offset(int'(sel_s), DATA_W) +: DATA_W]),
      .op  (op_r),
      .res (lane_res_s[l]),
      .ovf (lane_ovf_s[l])
    );
  end

  assign any_ovf_s = |(lane_ok_s & lane_ovf_s);

  // Control FSM with operand latch, result write-back and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= {MAT_W{1'b0}};
      b_r      <= {MAT_W{1'b0}};
      op_r     <= 1'b0;
      idx_r    <= {IDX_W{1'b0}};
      result_r <= {MAT_W{1'b0}};
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r      <= matrix_A;
            b_r      <= matrix_B;
            op_r     <= op;
            idx_r    <= {IDX_W{1'b0}};
            result_r <= {MAT_W{1'b0}};
            ovf_r    <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_ok_s[l]) begin
              result_r[elem_offset(int'(lane_idx_s[l]), DATA_W) +: DATA_W] <= lane_res_s[l];
            end
          end
          ovf_r <= ovf_r | any_ovf_s;
          idx_r <= idx_r + STEP_L;
          if (idx_r == LAST_L) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            done_r <= 1'b0;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign result_out = result_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Directed self-checking bench: three instances (LANES=1,4,5) share stimulus.
// Expected values follow MATRIX_SAT_EN when the bench is built with it.
module tb_matrix_addsub_seq;

  localparam int DATA_W = 8;
  localparam int DIM    = 5;
  localparam int NELEM  = DIM * DIM;
  localparam int MAT_W  = NELEM * DATA_W;

  logic             clk;
  logic             rst;
  logic             start;
  logic             op;
  logic [MAT_W-1:0] mat_a;
  logic [MAT_W-1:0] mat_b;
  logic [2:0]       busy_v;
  logic [2:0]       done_v;
  logic [2:0]       ovf_v;
  logic [MAT_W-1:0] res0;
  logic [MAT_W-1:0] res1;
  logic [MAT_W-1:0] res2;

  int checks;
  int failures;
  int ngrp [3];
  int busy_cnt [3];
  int done_cnt [3];
  int done_at [3];

  matrix_addsub_seq #(.DATA_W(DATA_W), .DIM(DIM), .LANES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .matrix_A(mat_a), .matrix_B(mat_b),
    .busy(busy_v[0]), .done(done_v[0]), .result_out(res0), .overflow(ovf_v[0]));

  matrix_addsub_seq #(.DATA_W(DATA_W), .DIM(DIM), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .op(op), .matrix_A(mat_a), .matrix_B(mat_b),
    .busy(busy_v[1]), .done(done_v[1]), .result_out(res1), .overflow(ovf_v[1]));

  matrix_addsub_seq #(.DATA_W(DATA_W), .DIM(DIM), .LANES(5)) dut5 (
    .clk(clk), .rst(rst), .start(start), .op(op), .matrix_A(mat_a), .matrix_B(mat_b),
    .busy(busy_v[2]), .done(done_v[2]), .result_out(res2), .overflow(ovf_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [7:0] elem(input int d, input int k);
    case (d)
      0:       return res0[k*DATA_W +: DATA_W];
      1:       return res1[k*DATA_W +: DATA_W];
      default: return res2[k*DATA_W +: DATA_W];
    endcase
  endfunction

  task automatic fill(input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < NELEM; k++) begin
      mat_a[k*DATA_W +: DATA_W] = a;
      mat_b[k*DATA_W +: DATA_W] = b;
    end
  endtask

  task automatic sample(input int c);
    for (int d = 0; d < 3; d++) begin
      if (busy_v[d]) busy_cnt[d]++;
      if (done_v[d]) begin
        done_cnt[d]++;
        done_at[d] = c;
      end
    end
  endtask

  // Pulse start, scramble inputs after the start edge, observe 31 cycles.
  task automatic do_op(input logic o);
    for (int d = 0; d < 3; d++) begin
      busy_cnt[d] = 0; done_cnt[d] = 0; done_at[d] = -1;
    end
    @(negedge clk); op = o; start = 1'b1;
    @(negedge clk); start = 1'b0;
    sample(0);
    mat_a = ~mat_a; mat_b = ~mat_b; op = ~o;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      sample(c);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 1'b0; mat_a = '0; mat_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy_v[d] !== 1'b0) begin failures++; $display("FAIL reset_busy dut%0d got %b want 0", d, busy_v[d]); end
      checks++;
      if (done_v[d] !== 1'b0) begin failures++; $display("FAIL reset_done dut%0d got %b want 0", d, done_v[d]); end
      checks++;
      if (ovf_v[d] !== 1'b0) begin failures++; $display("FAIL reset_ovf dut%0d got %b want 0", d, ovf_v[d]); end
    end
    checks++;
    if ((res0 | res1 | res2) !== {MAT_W{1'b0}}) begin failures++; $display("FAIL reset_result got nonzero want 0"); end
  endtask

  task automatic test_sub_basic;
    fill(8'd100, 8'd27);
    do_op(1'b1);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy_cnt[d] != ngrp[d] + 1) begin failures++; $display("FAIL busy_cycles dut%0d got %0d want %0d", d, busy_cnt[d], ngrp[d] + 1); end
      checks++;
      if (done_cnt[d] != 1) begin failures++; $display("FAIL done_pulses dut%0d got %0d want 1", d, done_cnt[d]); end
      checks++;
      if (done_at[d] != ngrp[d]) begin failures++; $display("FAIL done_latency dut%0d got %0d want %0d", d, done_at[d], ngrp[d]); end
      checks++;
      if (ovf_v[d] !== 1'b0) begin failures++; $display("FAIL sub_basic_ovf dut%0d got %b want 0", d, ovf_v[d]); end
      for (int k = 0; k < NELEM; k++) begin
        checks++;
        if (elem(d, k) !== 8'sd73) begin failures++; $display("FAIL sub_basic dut%0d elem%0d got %0d want 73", d, k, elem(d, k)); end
      end
    end
  endtask

  task automatic test_neg_sub;
    logic signed [7:0] exp;
    for (int k = 0; k < NELEM; k++) begin
      mat_a[k*DATA_W +: DATA_W] = 8'(-32'sd5 * (k + 32'sd1));
      mat_b[k*DATA_W +: DATA_W] = 8'(-(k + 32'sd1));
    end
    do_op(1'b1);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ovf_v[d] !== 1'b0) begin failures++; $display("FAIL neg_sub_ovf dut%0d got %b want 0", d, ovf_v[d]); end
      for (int k = 0; k < NELEM; k++) begin
        exp = 8'(-32'sd4 * (k + 32'sd1));
        checks++;
        if (elem(d, k) !== exp) begin failures++; $display("FAIL neg_sub dut%0d elem%0d got %0d want %0d", d, k, elem(d, k), exp); end
      end
    end
    checks++;
    if (elem(1, 24) !== -8'sd100) begin failures++; $display("FAIL lanes4_elem24 got %0d want -100", elem(1, 24)); end
  endtask

  task automatic test_overflow(input string name, input logic [7:0] a, input logic [7:0] b,
                               input logic o, input logic signed [7:0] exp_wrap,
                               input logic signed [7:0] exp_sat);
    logic signed [7:0] exp;
`ifdef MATRIX_SAT_EN
    exp = exp_sat;
`else
    exp = exp_wrap;
`endif
    fill(a, b);
    do_op(o);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ovf_v[d] !== 1'b1) begin failures++; $display("FAIL %s_ovf dut%0d got %b want 1", name, d, ovf_v[d]); end
      for (int k = 0; k < NELEM; k++) begin
        checks++;
        if (elem(d, k) !== exp) begin failures++; $display("FAIL %s dut%0d elem%0d got %0d want %0d", name, d, k, elem(d, k), exp); end
      end
    end
  endtask

  task automatic test_reset_mid_op;
    int d0_done;
    d0_done = 0;
    fill(8'd100, 8'd100);
    @(negedge clk); op = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 4) start = 1'b1;
      if (c == 5) start = 1'b0;
      @(negedge clk);
      if (done_v[0]) d0_done++;
      if (c == 7) begin
        checks++;
        if (busy_v[2] !== 1'b0) begin failures++; $display("FAIL start_not_queued got busy=%b want 0", busy_v[2]); end
      end
    end
    checks++;
    if (ovf_v[0] !== 1'b1) begin failures++; $display("FAIL pre_reset_ovf got %b want 1", ovf_v[0]); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    if (done_v[0]) d0_done++;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || ovf_v[d] !== 1'b0) begin
        failures++; $display("FAIL abort_outputs dut%0d got busy=%b done=%b ovf=%b want 0", d, busy_v[d], done_v[d], ovf_v[d]);
      end
    end
    checks++;
    if ((res0 | res1 | res2) !== {MAT_W{1'b0}}) begin failures++; $display("FAIL abort_result got nonzero want 0"); end
    repeat (30) begin
      @(negedge clk);
      if (done_v[0]) d0_done++;
    end
    checks++;
    if (d0_done != 0 || busy_v !== 3'b000) begin failures++; $display("FAIL abort_quiet got done=%0d busy=%b want 0 000", d0_done, busy_v); end
    fill(8'd1, 8'd2);
    do_op(1'b0);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (done_cnt[d] != 1 || ovf_v[d] !== 1'b0) begin failures++; $display("FAIL post_abort dut%0d got done=%0d ovf=%b want 1 0", d, done_cnt[d], ovf_v[d]); end
      checks++;
      if (elem(d, 0) !== 8'sd3 || elem(d, 24) !== 8'sd3) begin
        failures++; $display("FAIL post_abort_data dut%0d got %0d,%0d want 3,3", d, elem(d, 0), elem(d, 24));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic b0 [32];
    logic b2 [32];
    fill(8'd10, 8'd3);
    @(negedge clk); op = 1'b1; start = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      b0[c] = busy_v[0];
      b2[c] = busy_v[2];
    end
    start = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (b2[5] !== 1'b1 || b2[6] !== 1'b0 || b2[7] !== 1'b1) begin
      failures++; $display("FAIL b2b_lanes5 got %b%b%b want 101", b2[5], b2[6], b2[7]);
    end
    checks++;
    if (b0[25] !== 1'b1 || b0[26] !== 1'b0 || b0[27] !== 1'b1) begin
      failures++; $display("FAIL b2b_lanes1 got %b%b%b want 101", b0[25], b0[26], b0[27]);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy_v[d] !== 1'b0 || elem(d, 12) !== 8'sd7) begin
        failures++; $display("FAIL b2b_final dut%0d got busy=%b elem=%0d want 0 7", d, busy_v[d], elem(d, 12));
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    ngrp[0] = 25; ngrp[1] = 7; ngrp[2] = 5;
    test_reset();
    test_sub_basic();
    test_neg_sub();
    test_overflow("ovf_pos_sub", 8'd127, 8'h80, 1'b1, -8'sd1, 8'sd127);
    test_overflow("ovf_add", 8'd100, 8'd100, 1'b0, -8'sd56, 8'sd127);
    test_overflow("ovf_neg_sub", 8'h80, 8'd1, 1'b1, 8'sd127, -8'sd128);
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
